// File: rtl/counter8_pkg.sv
// Shared constants, types and helpers for the counter snapshot FIFO.
// Imported by the FIFO top, its output interface and the edge detector.
package counter8_pkg;

    localparam int COUNT_W    = 8;
    localparam int DEPTH_DEF  = 4;
    localparam int DROP_CNT_W = 8;

    typedef logic [DROP_CNT_W-1:0] drop_cnt_t;

    // Overflow bookkeeping kept together so clear and drop resolve in one place.
    typedef struct packed {
        logic      overflow;
        drop_cnt_t drop_cnt;
    } ovf_status_t;

    function automatic drop_cnt_t drop_sat_inc(input drop_cnt_t v);
        return (&v) ? v : v + drop_cnt_t'(1);
    endfunction

endpackage

// File: rtl/counter8_snapshot_fifo_if.sv
// Valid/ready output stream of the snapshot FIFO.
// The FIFO side uses master; the consumer side uses slave.
interface counter8_snapshot_fifo_if
    import counter8_pkg::*;
#(
    parameter int COUNT_W = counter8_pkg::COUNT_W
) ();

    logic               out_valid;
    logic               out_ready;
    logic [COUNT_W-1:0] out_data;

    modport master (
        output out_valid,
        output out_data,
        input  out_ready
    );

    modport slave (
        input  out_valid,
        input  out_data,
        output out_ready
    );

endinterface

// File: rtl/counter8_rise_detect.sv
// Single-cycle rising-edge detector for the capture trigger.
// The delay register resets high so a level already high at reset release is ignored.
module counter8_rise_detect
    import counter8_pkg::*;
(
    input  logic clk,
    input  logic reset_n,
    input  logic d,
    output logic rise
);

    logic d_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            d_q <= 1'b1;
        end else begin
            d_q <= d;
        end
    end

    assign rise = d & ~d_q;

endmodule

// File: rtl/counter8_snapshot_fifo.sv
// Captures the live counter value on each trigger rising edge into a small
// first-word-fall-through FIFO, with sticky overflow and saturating drop count.
module counter8_snapshot_fifo
    import counter8_pkg::*;
#(
    parameter int COUNT_W = counter8_pkg::COUNT_W,
    parameter int DEPTH   = DEPTH_DEF
) (
    input  logic                           clk,
    input  logic                           reset_n,
    input  logic [COUNT_W-1:0]             count_in,
    input  logic                           trig_in,
    counter8_snapshot_fifo_if.master       out_if,
    output logic [$clog2(DEPTH):0]         level,
    output logic                           overflow,
    output logic [DROP_CNT_W-1:0]          drop_cnt,
    input  logic                           clr_ovf
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = PTR_W + 1;

    typedef logic [PTR_W-1:0] ptr_t;
    typedef logic [LVL_W-1:0] lvl_t;

    logic               push;
    logic               pop;
    logic               full;
    logic               wr_en;
    logic               drop;

    ptr_t               wr_ptr_q, wr_ptr_d;
    ptr_t               rd_ptr_q, rd_ptr_d;
    lvl_t               level_q,  level_d;
    logic               valid_q,  valid_d;
    ovf_status_t        status_q, status_d;

    logic [COUNT_W-1:0] mem_q [DEPTH];

    counter8_rise_detect u_rise (
        .clk     (clk),
        .reset_n (reset_n),
        .d       (trig_in),
        .rise    (push)
    );

    // A pop frees the slot in the same cycle, so a full FIFO still accepts a push alongside it.
    always_comb begin
        pop   = valid_q & out_if.out_ready;
        full  = (level_q == lvl_t'(DEPTH));
        wr_en = push & (~full | pop);
        drop  = push & full & ~pop;

        wr_ptr_d = wr_en ? wr_ptr_q + ptr_t'(1) : wr_ptr_q;
        rd_ptr_d = pop   ? rd_ptr_q + ptr_t'(1) : rd_ptr_q;

        level_d = level_q;
        case ({wr_en, pop})
            2'b10:   level_d = level_q + lvl_t'(1);
            2'b01:   level_d = level_q - lvl_t'(1);
            default: level_d = level_q;
        endcase

        valid_d = (level_d != '0);

        // A drop in the clearing cycle is recorded as the first drop after the clear.
        status_d = status_q;
        if (clr_ovf) begin
            status_d.overflow = drop;
            status_d.drop_cnt = drop_cnt_t'(drop);
        end else if (drop) begin
            status_d.overflow = 1'b1;
            status_d.drop_cnt = drop_sat_inc(status_q.drop_cnt);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            valid_q  <= 1'b0;
            status_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
            valid_q  <= valid_d;
            status_q <= status_d;
        end
    end

    // Storage holds no reset; validity is tracked entirely by the level and pointers.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_ptr_q] <= count_in;
        end
    end

    assign out_if.out_valid = valid_q;
    assign out_if.out_data  = mem_q[rd_ptr_q];
    assign level            = level_q;
    assign overflow         = status_q.overflow;
    assign drop_cnt         = status_q.drop_cnt;

endmodule

// File: doc/counter8_snapshot_fifo.md
COUNTER8_SNAPSHOT_FIFO -- requirements
Module: counter8_snapshot_fifo

Interface
REQ-001 Parameter: COUNT_W, 8, width of the captured count value.
REQ-002 Parameter: DEPTH, 4, number of FIFO entries; power of two, 2..16.
REQ-003 Port: clk  input  1  single clock; all logic on its rising edge.
REQ-004 Port: reset_n  input  1  asynchronous, active-low reset.
REQ-005 Port: count_in  input  COUNT_W  live value from the upstream 8-bit counter, synchronous to clk.
REQ-006 Port: trig_in  input  1  capture trigger, synchronous to clk; a rising edge requests a snapshot.
REQ-007 Port: out_valid  output  1  FIFO head holds a snapshot.
REQ-008 Port: out_ready  input  1  consumer accepts the head.
REQ-009 Port: out_data  output  COUNT_W  snapshot at the FIFO head.
REQ-010 Port: level  output  clog2(DEPTH)+1  number of stored entries.
REQ-011 Port: overflow  output  1  sticky flag; a capture was dropped.
REQ-012 Port: drop_cnt  output  8  count of dropped captures, saturating.
REQ-013 Port: clr_ovf  input  1  synchronous clear of overflow and drop_cnt.

Function
REQ-014 The block SHALL register trig_in into trig_d each cycle; push = trig_in AND NOT trig_d.
REQ-015 On push, the block SHALL store the count_in value present in that same cycle.
REQ-016 The stored entry SHALL appear at the head with out_valid=1 on the cycle after push (1-cycle latency).
REQ-017 The FIFO SHALL be first-word-fall-through: out_data equals the head entry whenever out_valid=1; out_data is don't-care when out_valid=0.
REQ-018 A pop SHALL occur when out_valid AND out_ready; the head advances on the next cycle.
REQ-019 out_valid SHALL stay high and out_data SHALL stay stable until popped.
REQ-020 Read and write pointers SHALL be clog2(DEPTH) bits and wrap from DEPTH-1 to 0.
REQ-021 level SHALL be +1 on push only, -1 on pop only, and unchanged on simultaneous push and pop.
REQ-022 Full (level==DEPTH) with push and pop in the same cycle: the push SHALL be accepted and level SHALL stay at DEPTH.
REQ-023 Full with push and no pop: the capture SHALL be dropped; overflow SHALL be set to 1; drop_cnt SHALL increment.
REQ-024 drop_cnt SHALL saturate at 255.
REQ-025 Empty with push and out_ready=1: no pop occurs that cycle; the entry is stored.
REQ-026 clr_ovf=1 SHALL clear overflow and drop_cnt to 0 on the next cycle.
REQ-027 clr_ovf together with a drop in the same cycle SHALL result in overflow=1 and drop_cnt=1.
REQ-028 A trig_in held high SHALL produce exactly one push; any number of pushes requires trig_in to return low between them.

Reset
REQ-029 While reset_n=0: pointers=0, level=0, out_valid=0, overflow=0, drop_cnt=0, trig_d=1.
REQ-030 Because trig_d resets to 1, trig_in high at reset release SHALL NOT cause a capture.
REQ-031 Reset asserted mid-operation SHALL discard all stored entries immediately (asynchronously).
REQ-032 Storage array contents need not be reset.

Structure
REQ-033 Shared package counter8_pkg SHALL hold COUNT_W=8, default DEPTH=4 and the drop_cnt width constant.
REQ-034 Rising-edge detection SHALL be a sub-module counter8_rise_detect (clk, reset_n, d, rise), which resets its delay register to 1.
REQ-035 Pointers, level, flags and storage SHALL live in the top module; no FSM beyond that counter/pointer state is required.

Verification
REQ-036 Reset release with trig_in=1 -> no push; out_valid=0 and level=0 for 10 cycles.
REQ-037 count_in=8'h05 on a trig_in rising edge, out_ready=0 -> next cycle out_valid=1, out_data=8'h05, level=1; trig_in held high 5 cycles -> level stays 1.
REQ-038 Push 4 edges with counts 8'h10/8'h20/8'h30/8'h40 (DEPTH=4), then a fifth with 8'h50 -> level=4, overflow=1, drop_cnt=1; draining yields 10,20,30,40 in order.
REQ-039 Full, with push and pop in the same cycle at count 8'h60 -> level stays 4; drain order 20,30,40,60; overflow unchanged.
REQ-040 Hold full and issue 300 drops -> drop_cnt=255; clr_ovf pulse -> overflow=0, drop_cnt=0; clr_ovf coincident with a drop -> overflow=1, drop_cnt=1.
REQ-041 Three entries stored, reset_n pulsed low for 1 cycle -> out_valid=0 and level=0 immediately; the next push at 8'hA5 is read back as 8'hA5.
